// File: rtl/serial_inc_sequencer.sv
// Multi-cycle incrementer: one 2-bit increment slice reused over time,
// LSB pair first, with optional early exit once the carry dies.
module serial_inc_sequencer #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [WIDTH-1:0]                a_in,
   input  logic                            ci_in,
   output logic                            busy,
   output logic                            done,
   output logic [WIDTH-1:0]                s_out,
   output logic                            co_out,
   output logic [$clog2(WIDTH/2+1)-1:0]    slices_used
);

   localparam int NSLICE = WIDTH / 2;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int SW     = $clog2(NSLICE + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_op;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [IW-1:0]    r_idx;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_s;
   logic             r_co;
   logic [SW-1:0]    r_su;

   logic [IW:0]      w_base;
   logic [1:0]       w_pair;
   logic [2:0]       w_sum;
   logic             w_c;
   logic             w_last;
   logic             w_early;
   logic             w_stop;
   logic [WIDTH-1:0] w_hi_mask;
   logic [WIDTH-1:0] w_res_nxt;

   assign w_base    = {r_idx, 1'b0};
   assign w_pair    = r_op[w_base +: 2];
   assign w_sum     = {1'b0, w_pair} + {2'b00, r_carry};
   assign w_c       = w_sum[2];
   assign w_last    = (r_idx == IW'(NSLICE - 1));
   assign w_early   = EARLY_EXIT && !w_c && !w_last;
   assign w_stop    = w_last || w_early;
   // bits above the current slice; pass straight through on early exit
   assign w_hi_mask = {WIDTH{1'b1}} << (32'(w_base) + 32'd2);

   always_comb begin
      w_res_nxt = r_res;
      w_res_nxt[w_base +: 2] = w_sum[1:0];
      if (w_early) begin
         w_res_nxt = w_res_nxt | (r_op & w_hi_mask);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_s     <= '0;
         r_co    <= 1'b0;
         r_su    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_op    <= a_in;
                  r_carry <= ci_in;
                  r_idx   <= '0;
                  r_res   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_res   <= w_res_nxt;
               r_carry <= w_c;
               if (w_stop) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_s     <= w_res_nxt;
                  r_co    <= w_c;
                  r_su    <= SW'(r_idx) + SW'(1);
                  r_state <= S_DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign s_out       = r_s;
   assign co_out      = r_co;
   assign slices_used = r_su;

endmodule

// File: tb/tb_serial_inc_sequencer.sv
// Bench for serial_inc_sequencer: one instance per EARLY_EXIT setting,
// vector table, scoreboard queue, corner sequences and random ops.
module tb_serial_inc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a_in;
   logic       ci_in;
   logic       start0, start1;
   logic       busy0, busy1, done0, done1, co0, co1;
   logic [7:0] s0, s1;
   logic [2:0] su0, su1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      bit         ee;
      logic [7:0] a;
      logic       ci;
      logic [7:0] s;
      logic       co;
      logic [2:0] su;
   } vec_t;

   vec_t q[$];

   always #5 clk = ~clk;

   serial_inc_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_ne (
      .clk(clk), .rst(rst), .start(start0), .a_in(a_in), .ci_in(ci_in),
      .busy(busy0), .done(done0), .s_out(s0), .co_out(co0),
      .slices_used(su0)
   );

   serial_inc_sequencer #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_ee (
      .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .ci_in(ci_in),
      .busy(busy1), .done(done1), .s_out(s1), .co_out(co1),
      .slices_used(su1)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic sample(input bit ee, output logic b, output logic d,
                         output logic [7:0] s, output logic co,
                         output logic [2:0] su);
      b  = ee ? busy1 : busy0;
      d  = ee ? done1 : done0;
      s  = ee ? s1 : s0;
      co = ee ? co1 : co0;
      su = ee ? su1 : su0;
   endtask

   function automatic vec_t model(input bit ee, input logic [7:0] a,
                                  input logic ci);
      vec_t v;
      logic [8:0] sum;
      logic c;
      bit found;
      sum = {1'b0, a} + {8'b0, ci};
      v.ee = ee; v.a = a; v.ci = ci;
      v.s = sum[7:0]; v.co = sum[8];
      v.su = 3'd4;
      c = ci; found = 0;
      for (int i = 0; i < 4; i++) begin
         c = c && (a[2*i +: 2] == 2'b11);
         if (ee && !c && !found) begin
            v.su = 3'(i + 1);
            found = 1;
         end
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v);
      vec_t e;
      int cyc;
      logic b, d, co;
      logic [7:0] s, hold;
      logic [2:0] su;
      @(negedge clk);
      sample(v.ee, b, d, s, co, su);
      hold = s;
      a_in = v.a; ci_in = v.ci;
      if (v.ee) start1 = 1'b1; else start0 = 1'b1;
      q.push_back(v);
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      sample(v.ee, b, d, s, co, su);
      chk("busy_on_accept", 32'(b), 32'd1);
      chk("s_out_held", 32'(s), 32'(hold));
      cyc = 0;
      while (!d && cyc < 20) begin
         a_in = 8'($urandom); ci_in = 1'($urandom);
         @(posedge clk); #1;
         cyc++;
         sample(v.ee, b, d, s, co, su);
      end
      e = q.pop_front();
      if (!d) begin
         chk("done_timeout", 32'd0, 32'd1);
      end else begin
         chk("latency", 32'(cyc), 32'(e.su));
         chk("s_out", 32'(s), 32'(e.s));
         chk("co_out", 32'(co), 32'(e.co));
         chk("slices_used", 32'(su), 32'(e.su));
         chk("busy_at_done", 32'(b), 32'd0);
      end
      @(posedge clk); #1;
      sample(v.ee, b, d, s, co, su);
      chk("done_one_cycle", 32'(d), 32'd0);
   endtask

   vec_t tbl[10];

   initial begin
      int ndone, dc;
      tbl[0] = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b1, 3'd4};
      tbl[1] = '{1'b1, 8'h03, 1'b1, 8'h04, 1'b0, 3'd2};
      tbl[2] = '{1'b1, 8'h5A, 1'b0, 8'h5A, 1'b0, 3'd1};
      tbl[3] = '{1'b0, 8'h03, 1'b1, 8'h04, 1'b0, 3'd4};
      tbl[4] = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b1, 3'd4};
      tbl[5] = '{1'b1, 8'h0F, 1'b1, 8'h10, 1'b0, 3'd3};
      tbl[6] = '{1'b0, 8'h5A, 1'b0, 8'h5A, 1'b0, 3'd4};
      tbl[7] = '{1'b1, 8'h3F, 1'b1, 8'h40, 1'b0, 3'd4};
      tbl[8] = '{1'b1, 8'h0E, 1'b1, 8'h0F, 1'b0, 3'd1};
      tbl[9] = '{1'b0, 8'hBF, 1'b1, 8'hC0, 1'b0, 3'd4};

      rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
      a_in = 8'hFF; ci_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_done0", 32'(done0), 32'd0);
      chk("rst_s0", 32'(s0), 32'd0);
      chk("rst_co0", 32'(co0), 32'd0);
      chk("rst_su0", 32'(su0), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_done1", 32'(done1), 32'd0);
      chk("rst_s1", 32'(s1), 32'd0);
      chk("rst_co1", 32'(co1), 32'd0);
      chk("rst_su1", 32'(su1), 32'd0);
      start0 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_op(tbl[i]);

      // start re-pulsed while busy must be ignored
      @(negedge clk);
      a_in = 8'h3F; ci_in = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      ndone = 0; dc = 0;
      for (int c = 1; c <= 12; c++) begin
         if (c == 2) begin
            a_in = 8'h00; start1 = 1'b1;
         end
         @(posedge clk); #1;
         if (c == 2) start1 = 1'b0;
         if (done1) begin
            ndone++; dc = c;
            chk("repulse_s_out", 32'(s1), 32'h40);
            chk("repulse_co_out", 32'(co1), 32'd0);
         end
      end
      chk("repulse_done_count", 32'(ndone), 32'd1);
      chk("repulse_done_cycle", 32'(dc), 32'd4);
      run_op('{1'b1, 8'h3F, 1'b1, 8'h40, 1'b0, 3'd4});

      // reset in the middle of an op
      @(negedge clk);
      a_in = 8'hFF; ci_in = 1'b1; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_busy", 32'(busy1), 32'd0);
      chk("midrst_done", 32'(done1), 32'd0);
      chk("midrst_s_out", 32'(s1), 32'd0);
      chk("midrst_co_out", 32'(co1), 32'd0);
      chk("midrst_su", 32'(su1), 32'd0);
      ndone = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done1) ndone++;
      end
      chk("midrst_no_done", 32'(ndone), 32'd0);
      run_op('{1'b1, 8'h03, 1'b1, 8'h04, 1'b0, 3'd2});

      for (int n = 0; n < 1000; n++) begin
         run_op(model(1'b1, 8'($urandom), 1'($urandom)));
         run_op(model(1'b0, 8'($urandom), 1'($urandom)));
      end

      chk("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
